// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding-select and load-use hazard unit: tracks in-flight writers EX..WB and
// resolves each ID source operand against them, one resolver instance per operand.

module fwd_operand_resolve #(
    parameter int REG_AW   = 5,
    parameter int ZERO_REG = 31,
    parameter int DEPTH    = 3,
    parameter int SEL_W    = $clog2(DEPTH)
) (
    input  logic                              check,
    input  logic [REG_AW-1:0]                 src,
    input  logic [DEPTH-1:0]                  vld_pipe,
    input  logic [DEPTH-1:0]                  rw_pipe,
    input  logic [DEPTH-1:0]                  lat_pipe,
    input  logic [DEPTH-1:0][REG_AW-1:0]      rd_pipe,
    output logic [SEL_W-1:0]                  sel,
    output logic                              stall_req
);
    logic hit;

    // Youngest producer wins; WB (DEPTH-1) is excluded since the regfile writes through.
    always_comb begin
        sel       = '0;
        stall_req = 1'b0;
        hit       = 1'b0;
        for (int k = 0; k < DEPTH - 1; k++) begin
            if (!hit && check && vld_pipe[k] && rw_pipe[k] &&
                rd_pipe[k] == src && src != REG_AW'(ZERO_REG)) begin
                hit = 1'b1;
                if (k < int'(lat_pipe[k])) stall_req = 1'b1;
                else                       sel       = SEL_W'(k + 1);
            end
        end
    end
endmodule

module fwd_hazard_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int ZERO_REG = 31,
    parameter int NUM_SRC  = 3,
    parameter int DEPTH    = 3,
    parameter int SEL_W    = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        hold_ext,
    input  logic                        flush,
    input  logic                        id_valid,
    input  logic [REG_AW-1:0]           id_rd,
    input  logic                        id_regwrite,
    input  logic                        id_is_load,
    input  logic [NUM_SRC*REG_AW-1:0]   id_src,
    input  logic [NUM_SRC-1:0]          id_src_used,
    output logic [NUM_SRC*SEL_W-1:0]    fwd_sel,
    output logic                        hazard_stall,
    output logic [15:0]                 stall_count
);
    logic [DEPTH-1:0]               vld_pipe;
    logic [DEPTH-1:0]               rw_pipe;
    logic [DEPTH-1:0]               lat_pipe;
    logic [DEPTH-1:0][REG_AW-1:0]   rd_pipe;
    logic [NUM_SRC-1:0][SEL_W-1:0]  sel_c;
    logic [NUM_SRC-1:0][SEL_W-1:0]  fwd_sel_q;
    logic [NUM_SRC-1:0]             stall_req;
    logic [15:0]                    cnt_q;
    logic                           id_live;

    assign id_live = id_valid & ~flush;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_op
        fwd_operand_resolve #(
            .REG_AW(REG_AW), .ZERO_REG(ZERO_REG), .DEPTH(DEPTH), .SEL_W(SEL_W)
        ) u_op (
            .check     (id_live & id_src_used[i]),
            .src       (id_src[i*REG_AW +: REG_AW]),
            .vld_pipe  (vld_pipe),
            .rw_pipe   (rw_pipe),
            .lat_pipe  (lat_pipe),
            .rd_pipe   (rd_pipe),
            .sel       (sel_c[i]),
            .stall_req (stall_req[i])
        );
    end

    assign hazard_stall = (|stall_req) & ~flush & ~hold_ext;
    assign fwd_sel      = fwd_sel_q;
    assign stall_count  = cnt_q;

    // Stage 0 is the LSB entry; a stall or flush shifts in an invalid bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe  <= '0;
            rw_pipe   <= '0;
            lat_pipe  <= '0;
            rd_pipe   <= '0;
            fwd_sel_q <= '0;
            cnt_q     <= '0;
        end else if (!hold_ext) begin
            vld_pipe  <= {vld_pipe[DEPTH-2:0], id_live & ~hazard_stall};
            rw_pipe   <= {rw_pipe[DEPTH-2:0],  id_regwrite};
            lat_pipe  <= {lat_pipe[DEPTH-2:0], id_is_load};
            rd_pipe   <= {rd_pipe[DEPTH-2:0],  id_rd};
            fwd_sel_q <= (hazard_stall || !id_live) ? '0 : sel_c;
            if (hazard_stall && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
        end
    end
endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed bench for fwd_hazard_scoreboard: hand-computed selects, stalls and counts.

module tb_fwd_hazard_scoreboard;
    logic        clk = 1'b0;
    logic        reset;
    logic        hold_ext;
    logic        flush;
    logic        id_valid;
    logic [4:0]  id_rd;
    logic        id_regwrite;
    logic        id_is_load;
    logic [14:0] id_src;
    logic [2:0]  id_src_used;
    logic [5:0]  fwd_sel;
    logic        hazard_stall;
    logic [15:0] stall_count;

    int          nvec = 0;
    int          nerr = 0;
    logic [15:0] exp_cnt = 16'd0;

    fwd_hazard_scoreboard dut (
        .clk(clk), .reset(reset), .hold_ext(hold_ext), .flush(flush),
        .id_valid(id_valid), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_is_load(id_is_load), .id_src(id_src), .id_src_used(id_src_used),
        .fwd_sel(fwd_sel), .hazard_stall(hazard_stall), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task tick;
        @(posedge clk);
        #1;
    endtask

    task drive_nop;
        id_valid = 0; id_rd = 0; id_regwrite = 0; id_is_load = 0;
        id_src = 0; id_src_used = 0; flush = 0;
        #1;
    endtask

    task nops(input int n);
        for (int i = 0; i < n; i++) begin
            drive_nop();
            tick();
        end
    endtask

    task instr(input logic [4:0] rd, input logic rw, input logic ld,
               input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2,
               input logic [2:0] used);
        id_valid = 1; id_rd = rd; id_regwrite = rw; id_is_load = ld;
        id_src = {s2, s1, s0}; id_src_used = used; flush = 0;
        #1;
    endtask

    task test_reset;
        reset = 1; hold_ext = 0;
        drive_nop();
        tick(); tick();
        reset = 0;
        #1;
        nvec++; if (fwd_sel !== 6'h00) begin nerr++; $display("FAIL reset_sel: got %h want %h", fwd_sel, 6'h00); end
        nvec++; if (stall_count !== 16'h0) begin nerr++; $display("FAIL reset_cnt: got %h want %h", stall_count, 16'h0); end
        nvec++; if (hazard_stall !== 1'b0) begin nerr++; $display("FAIL reset_hz: got %b want 0", hazard_stall); end
    endtask

    task test_alu_b2b;
        nops(3);
        instr(5'd1, 1, 0, 5'd10, 5'd11, 5'd0, 3'b011);
        tick();
        instr(5'd2, 1, 0, 5'd1, 5'd3, 5'd0, 3'b011);
        nvec++; if (hazard_stall !== 1'b0) begin nerr++; $display("FAIL alu_b2b_hz: got %b want 0", hazard_stall); end
        tick();
        nvec++; if (fwd_sel !== 6'b000001) begin nerr++; $display("FAIL alu_b2b_sel: got %b want %b", fwd_sel, 6'b000001); end
    endtask

    task test_distance;
        nops(3);
        instr(5'd1, 1, 0, 5'd10, 5'd11, 5'd0, 3'b011);
        tick();
        nops(1);
        instr(5'd4, 1, 0, 5'd1, 5'd1, 5'd0, 3'b011);
        nvec++; if (hazard_stall !== 1'b0) begin nerr++; $display("FAIL dist2_hz: got %b want 0", hazard_stall); end
        tick();
        nvec++; if (fwd_sel !== 6'b001010) begin nerr++; $display("FAIL dist2_sel: got %b want %b", fwd_sel, 6'b001010); end
        nops(3);
        instr(5'd1, 1, 0, 5'd10, 5'd11, 5'd0, 3'b011);
        tick();
        nops(2);
        instr(5'd4, 1, 0, 5'd1, 5'd1, 5'd0, 3'b011);
        tick();
        nvec++; if (fwd_sel !== 6'b000000) begin nerr++; $display("FAIL dist3_sel: got %b want %b", fwd_sel, 6'b000000); end
    endtask

    task test_load_use;
        nops(3);
        instr(5'd5, 1, 1, 5'd20, 5'd0, 5'd0, 3'b001);
        tick();
        instr(5'd6, 1, 0, 5'd5, 5'd7, 5'd0, 3'b011);
        nvec++; if (hazard_stall !== 1'b1) begin nerr++; $display("FAIL lu_hz_first: got %b want 1", hazard_stall); end
        tick();
        exp_cnt = exp_cnt + 16'd1;
        nvec++; if (fwd_sel !== 6'b000000) begin nerr++; $display("FAIL lu_bubble_sel: got %b want %b", fwd_sel, 6'b000000); end
        nvec++; if (stall_count !== exp_cnt) begin nerr++; $display("FAIL lu_cnt: got %h want %h", stall_count, exp_cnt); end
        nvec++; if (hazard_stall !== 1'b0) begin nerr++; $display("FAIL lu_hz_second: got %b want 0", hazard_stall); end
        tick();
        nvec++; if (fwd_sel !== 6'b000010) begin nerr++; $display("FAIL lu_sel: got %b want %b", fwd_sel, 6'b000010); end
    endtask

    task test_priority;
        nops(3);
        instr(5'd1, 1, 0, 5'd10, 5'd11, 5'd0, 3'b011);
        tick();
        instr(5'd1, 1, 0, 5'd12, 5'd13, 5'd0, 3'b011);
        tick();
        instr(5'd2, 1, 0, 5'd1, 5'd0, 5'd0, 3'b001);
        tick();
        nvec++; if (fwd_sel !== 6'b000001) begin nerr++; $display("FAIL youngest_sel: got %b want %b", fwd_sel, 6'b000001); end
        // Mixed operands: X2 in EX, X1 in MEM, operand 2 not read.
        nops(3);
        instr(5'd1, 1, 0, 5'd10, 5'd11, 5'd0, 3'b011);
        tick();
        instr(5'd2, 1, 0, 5'd10, 5'd11, 5'd0, 3'b011);
        tick();
        instr(5'd3, 1, 0, 5'd2, 5'd1, 5'd2, 3'b011);
        tick();
        nvec++; if (fwd_sel !== 6'b001001) begin nerr++; $display("FAIL mixed_sel: got %b want %b", fwd_sel, 6'b001001); end
        nops(3);
        instr(5'd31, 1, 1, 5'd10, 5'd0, 5'd0, 3'b001);
        tick();
        instr(5'd8, 1, 0, 5'd31, 5'd31, 5'd31, 3'b111);
        nvec++; if (hazard_stall !== 1'b0) begin nerr++; $display("FAIL zero_reg_hz: got %b want 0", hazard_stall); end
        tick();
        nvec++; if (fwd_sel !== 6'b000000) begin nerr++; $display("FAIL zero_reg_sel: got %b want %b", fwd_sel, 6'b000000); end
    endtask

    task test_flush;
        nops(3);
        instr(5'd5, 1, 1, 5'd20, 5'd0, 5'd0, 3'b001);
        tick();
        instr(5'd6, 1, 0, 5'd5, 5'd0, 5'd0, 3'b001);
        flush = 1;
        #1;
        nvec++; if (hazard_stall !== 1'b0) begin nerr++; $display("FAIL flush_hz: got %b want 0", hazard_stall); end
        tick();
        nvec++; if (stall_count !== exp_cnt) begin nerr++; $display("FAIL flush_cnt: got %h want %h", stall_count, exp_cnt); end
        nvec++; if (fwd_sel !== 6'b000000) begin nerr++; $display("FAIL flush_sel: got %b want %b", fwd_sel, 6'b000000); end
        instr(5'd9, 1, 0, 5'd6, 5'd0, 5'd0, 3'b001);
        tick();
        nvec++; if (fwd_sel !== 6'b000000) begin nerr++; $display("FAIL flush_squashed_sel: got %b want %b", fwd_sel, 6'b000000); end
    endtask

    task test_hold;
        nops(3);
        instr(5'd1, 1, 0, 5'd10, 5'd11, 5'd0, 3'b011);
        tick();
        instr(5'd5, 1, 1, 5'd1, 5'd0, 5'd0, 3'b001);
        tick();
        instr(5'd6, 1, 0, 5'd5, 5'd0, 5'd0, 3'b001);
        hold_ext = 1;
        #1;
        nvec++; if (hazard_stall !== 1'b0) begin nerr++; $display("FAIL hold_hz: got %b want 0", hazard_stall); end
        tick(); tick(); tick();
        nvec++; if (fwd_sel !== 6'b000001) begin nerr++; $display("FAIL hold_sel: got %b want %b", fwd_sel, 6'b000001); end
        nvec++; if (stall_count !== exp_cnt) begin nerr++; $display("FAIL hold_cnt: got %h want %h", stall_count, exp_cnt); end
        hold_ext = 0;
        #1;
        nvec++; if (hazard_stall !== 1'b1) begin nerr++; $display("FAIL release_hz: got %b want 1", hazard_stall); end
        tick();
        exp_cnt = exp_cnt + 16'd1;
        nvec++; if (fwd_sel !== 6'b000000) begin nerr++; $display("FAIL release_bubble: got %b want %b", fwd_sel, 6'b000000); end
        nvec++; if (stall_count !== exp_cnt) begin nerr++; $display("FAIL release_cnt: got %h want %h", stall_count, exp_cnt); end
        tick();
        nvec++; if (fwd_sel !== 6'b000010) begin nerr++; $display("FAIL release_sel: got %b want %b", fwd_sel, 6'b000010); end
    endtask

    task test_saturation;
        nops(3);
        // Preload near the top so saturation is reached in a few stalls.
        force dut.cnt_q = 16'hFFFD;
        #1;
        release dut.cnt_q;
        exp_cnt = 16'hFFFD;
        for (int i = 0; i < 3; i++) begin
            instr(5'd5, 1, 1, 5'd20, 5'd0, 5'd0, 3'b000);
            tick();
            instr(5'd6, 1, 0, 5'd5, 5'd0, 5'd0, 3'b001);
            nvec++; if (hazard_stall !== 1'b1) begin nerr++; $display("FAIL sat_hz[%0d]: got %b want 1", i, hazard_stall); end
            tick();
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            nvec++; if (stall_count !== exp_cnt) begin nerr++; $display("FAIL sat_cnt[%0d]: got %h want %h", i, stall_count, exp_cnt); end
        end
    endtask

    task test_reset_mid_stall;
        instr(5'd5, 1, 1, 5'd20, 5'd0, 5'd0, 3'b000);
        tick();
        instr(5'd6, 1, 0, 5'd5, 5'd0, 5'd0, 3'b001);
        nvec++; if (hazard_stall !== 1'b1) begin nerr++; $display("FAIL rst_stall_hz_pre: got %b want 1", hazard_stall); end
        reset = 1;
        tick();
        reset = 0;
        #1;
        exp_cnt = 16'd0;
        nvec++; if (hazard_stall !== 1'b0) begin nerr++; $display("FAIL rst_stall_hz: got %b want 0", hazard_stall); end
        nvec++; if (fwd_sel !== 6'b000000) begin nerr++; $display("FAIL rst_stall_sel: got %b want %b", fwd_sel, 6'b000000); end
        nvec++; if (stall_count !== exp_cnt) begin nerr++; $display("FAIL rst_stall_cnt: got %h want %h", stall_count, exp_cnt); end
    endtask

    initial begin
        test_reset();
        test_alu_b2b();
        test_distance();
        test_load_use();
        test_priority();
        test_flush();
        test_hold();
        test_saturation();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
